// File: rtl/ucaspian_axon_delay.sv
// Axon stage: maps a firing neuron to its synapse range, either immediately (delay 0)
// or through a per-neuron delay-queue bitfield drained by the per-timestep scan.
module ucaspian_axon_delay #(
  parameter int unsigned NEURON_AW = 8,
  parameter int unsigned SYN_AW    = 12,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DELAY_W   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              clear,
  output logic                              clear_done,
  input  logic [NEURON_AW-1:0]              cfg_addr,
  input  logic [DELAY_W+SYN_AW+CNT_W-1:0]   cfg_data,
  input  logic                              cfg_we,
  input  logic                              next_step,
  output logic                              step_done,
  input  logic [NEURON_AW-1:0]              axon_addr,
  input  logic                              axon_vld,
  output logic                              axon_rdy,
  output logic [SYN_AW-1:0]                 syn_start,
  output logic [SYN_AW-1:0]                 syn_end,
  output logic                              syn_vld,
  input  logic                              syn_rdy
);

  localparam int unsigned N     = 2 ** NEURON_AW;
  localparam int unsigned DMAX  = 2 ** DELAY_W - 1;
  localparam int unsigned CFG_W = DELAY_W + SYN_AW + CNT_W;
  localparam logic [DMAX-1:0] DmaxOne = DMAX'(1);

  localparam logic [2:0] StWipe    = 3'd0;
  localparam logic [2:0] StIdle    = 3'd1;
  localparam logic [2:0] StClear   = 3'd2;
  localparam logic [2:0] StClrWait = 3'd3;
  localparam logic [2:0] StScan    = 3'd4;

  logic [CFG_W-1:0] cfg_mem [N];
  logic [DMAX-1:0]  dly_mem [N];

  logic [2:0]           state_q, state_d;
  logic [NEURON_AW:0]   ctr_q, ctr_d;
  logic                 pend_q, pend_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [NEURON_AW-1:0] s1_addr_q, s1_addr_d;
  logic                 st_vld_q, st_vld_d;
  logic [NEURON_AW-1:0] st_addr_q, st_addr_d;
  logic [CFG_W-1:0]     st_cfg_q;
  logic [DMAX-1:0]      st_queue_q;
  logic                 syn_vld_q, syn_vld_d;
  logic [SYN_AW-1:0]    syn_start_q, syn_start_d, syn_end_q, syn_end_d;
  logic                 clear_done_q, clear_done_d, step_done_q, step_done_d;

  logic                 out_busy, adv, is_idle, scan_mode, accept, pipe_empty;
  logic                 sweep_last, scan_issue, start_scan;
  logic [NEURON_AW-1:0] rd_addr;
  logic [DELAY_W-1:0]   ev_delay;
  logic [SYN_AW-1:0]    ev_first;
  logic [CNT_W-1:0]     ev_count;
  logic                 ev_go, ev_emit, ev_wr;
  logic [DMAX-1:0]      ev_wdata;
  logic                 dly_we, cfg_mem_we, fwd;
  logic [NEURON_AW-1:0] dly_waddr, cfg_waddr;
  logic [DMAX-1:0]      dly_wdata;
  logic [CFG_W-1:0]     cfg_wdata;

  assign out_busy   = syn_vld_q && !syn_rdy;
  assign adv        = enable && !out_busy;
  assign is_idle    = (state_q == StIdle);
  assign scan_mode  = (state_q == StScan);
  assign axon_rdy   = enable && is_idle && !clear && !out_busy;
  assign accept     = axon_vld && axon_rdy;
  assign pipe_empty = !s1_vld_q && !st_vld_q;
  assign sweep_last = (ctr_q[NEURON_AW-1:0] == {NEURON_AW{1'b1}});
  assign scan_issue = scan_mode && !ctr_q[NEURON_AW];
  assign start_scan = is_idle && !clear && (next_step || pend_q) && pipe_empty;
  assign rd_addr    = scan_mode ? ctr_q[NEURON_AW-1:0] : s1_addr_q;

  assign ev_delay = st_cfg_q[CFG_W-1 -: DELAY_W];
  assign ev_first = st_cfg_q[CNT_W +: SYN_AW];
  assign ev_count = st_cfg_q[CNT_W-1:0];
  assign ev_go    = adv && st_vld_q && (is_idle || scan_mode);

  // Fire mode queues or emits directly; scan mode emits bit 0 and shifts the queue down.
  always_comb begin
    ev_emit  = 1'b0;
    ev_wr    = 1'b0;
    ev_wdata = st_queue_q;
    if (scan_mode) begin
      ev_emit  = st_queue_q[0] && (ev_count != '0);
      ev_wr    = (st_queue_q != '0);
      ev_wdata = st_queue_q >> 1;
    end else if (ev_delay == '0) begin
      ev_emit  = (ev_count != '0);
    end else begin
      ev_wr    = 1'b1;
      ev_wdata = st_queue_q | (DmaxOne << (ev_delay - DELAY_W'(1)));
    end
  end

  always_comb begin
    if ((state_q == StWipe || state_q == StClear) && enable) begin
      dly_we    = 1'b1;
      dly_waddr = ctr_q[NEURON_AW-1:0];
      dly_wdata = '0;
    end else begin
      dly_we    = ev_go && ev_wr;
      dly_waddr = st_addr_q;
      dly_wdata = ev_wdata;
    end
    if (state_q == StClear) begin
      cfg_mem_we = enable;
      cfg_waddr  = ctr_q[NEURON_AW-1:0];
      cfg_wdata  = '0;
    end else begin
      cfg_mem_we = cfg_we && !clear;
      cfg_waddr  = cfg_addr;
      cfg_wdata  = cfg_data;
    end
  end

  // A back-to-back fire to the same neuron must see the write-back of the one ahead of it.
  assign fwd = dly_we && (dly_waddr == rd_addr);

  always_ff @(posedge clk) begin
    if (dly_we) dly_mem[dly_waddr] <= dly_wdata;
    if (cfg_mem_we) cfg_mem[cfg_waddr] <= cfg_wdata;
    if (adv) begin
      st_cfg_q   <= cfg_mem[rd_addr];
      st_queue_q <= fwd ? dly_wdata : dly_mem[rd_addr];
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_addr_d = s1_addr_q;
    st_vld_d  = st_vld_q;
    st_addr_d = st_addr_q;
    if (enable && (state_q == StClear || state_q == StClrWait)) begin
      s1_vld_d = 1'b0;
      st_vld_d = 1'b0;
    end else if (adv) begin
      s1_vld_d  = accept;
      s1_addr_d = axon_addr;
      if (scan_mode) begin
        st_vld_d  = scan_issue;
        st_addr_d = ctr_q[NEURON_AW-1:0];
      end else begin
        st_vld_d  = s1_vld_q && is_idle;
        st_addr_d = s1_addr_q;
      end
    end
  end

  always_comb begin
    syn_vld_d   = syn_vld_q;
    syn_start_d = syn_start_q;
    syn_end_d   = syn_end_q;
    if (enable && syn_vld_q && syn_rdy) syn_vld_d = 1'b0;
    if (ev_go && ev_emit) begin
      syn_vld_d   = 1'b1;
      syn_start_d = ev_first;
      syn_end_d   = ev_first + SYN_AW'(ev_count) - SYN_AW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    pend_d       = pend_q;
    clear_done_d = 1'b0;
    step_done_d  = 1'b0;
    if (enable) begin
      unique case (state_q)
        StWipe: begin
          ctr_d = ctr_q + 1'b1;
          if (sweep_last) begin
            ctr_d   = '0;
            state_d = StIdle;
          end
        end
        StClear: begin
          ctr_d = ctr_q + 1'b1;
          if (sweep_last) begin
            ctr_d        = '0;
            clear_done_d = 1'b1;
            state_d      = clear ? StClrWait : StIdle;
          end
        end
        StClrWait: if (!clear) state_d = StIdle;
        StIdle: begin
          ctr_d = '0;
          if (clear) state_d = StClear;
          else if (start_scan) state_d = StScan;
        end
        StScan: begin
          if (ctr_q[NEURON_AW] && !st_vld_q && !syn_vld_q) begin
            ctr_d       = '0;
            step_done_d = 1'b1;
            state_d     = StIdle;
          end else if (adv && scan_issue) begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        default: state_d = StWipe;
      endcase
      if (start_scan) pend_d = 1'b0;
      else if (next_step) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWipe;
      ctr_q        <= '0;
      pend_q       <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_addr_q    <= '0;
      st_vld_q     <= 1'b0;
      st_addr_q    <= '0;
      syn_vld_q    <= 1'b0;
      syn_start_q  <= '0;
      syn_end_q    <= '0;
      clear_done_q <= 1'b0;
      step_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      pend_q       <= pend_d;
      s1_vld_q     <= s1_vld_d;
      s1_addr_q    <= s1_addr_d;
      st_vld_q     <= st_vld_d;
      st_addr_q    <= st_addr_d;
      syn_vld_q    <= syn_vld_d;
      syn_start_q  <= syn_start_d;
      syn_end_q    <= syn_end_d;
      clear_done_q <= clear_done_d;
      step_done_q  <= step_done_d;
    end
  end

  assign clear_done = clear_done_q;
  assign step_done  = step_done_q;
  assign syn_vld    = syn_vld_q;
  assign syn_start  = syn_start_q;
  assign syn_end    = syn_end_q;

endmodule

// File: tb/tb_ucaspian_axon_delay.sv
// Directed bench for ucaspian_axon_delay: immediate fires, delayed fires, merge,
// back-to-back, output stall, wrap-around, pending steps, clear and reset.
module tb_ucaspian_axon_delay;

  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b1, clear = 1'b0;
  logic        clear_done, step_done, axon_rdy, syn_vld;
  logic [7:0]  cfg_addr = '0, axon_addr = '0;
  logic [23:0] cfg_data = '0;
  logic        cfg_we = 1'b0, next_step = 1'b0, axon_vld = 1'b0, syn_rdy = 1'b1;
  logic [11:0] syn_start, syn_end;

  int vec_cnt = 0, err_cnt = 0;
  int em_n;
  logic [11:0] em_start [8];
  logic [11:0] em_end [8];
  logic got_done, stall_ok;

  ucaspian_axon_delay dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .clear_done(clear_done),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we), .next_step(next_step),
    .step_done(step_done), .axon_addr(axon_addr), .axon_vld(axon_vld), .axon_rdy(axon_rdy),
    .syn_start(syn_start), .syn_end(syn_end), .syn_vld(syn_vld), .syn_rdy(syn_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] cfgw(input int d, input int first, input int cnt);
    return {d[3:0], first[11:0], cnt[7:0]};
  endfunction

  task automatic cfg_write(input int a, input logic [23:0] d);
    cfg_addr = a[7:0];
    cfg_data = d;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Waits (bounded) for axon_rdy, then presents one fire for exactly one accepting edge.
  task automatic fire(input int a);
    int n = 0;
    while (!axon_rdy && n < 600) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (!axon_rdy) begin
      err_cnt++;
      $display("FAIL fire_rdy addr=%0d axon_rdy=%b required 1", a, axon_rdy);
    end
    axon_addr = a[7:0];
    axon_vld  = 1'b1;
    tick();
    axon_vld  = 1'b0;
  endtask

  // Pulses next_step and collects transfers until step_done; stalls the first output
  // for `stall` cycles and notes whether it stayed stable.
  task automatic run_scan(input int stall);
    int st = stall;
    logic stalling = 1'b0;
    logic [11:0] hs = '0, he = '0;
    em_n = 0;
    got_done = 1'b0;
    stall_ok = 1'b1;
    next_step = 1'b1;
    tick();
    next_step = 1'b0;
    for (int i = 0; i < 1500 && !got_done; i++) begin
      if (step_done) begin
        got_done = 1'b1;
      end else if (syn_vld) begin
        if (stalling && (syn_start !== hs || syn_end !== he)) stall_ok = 1'b0;
        if (st > 0) begin
          if (!stalling) begin
            hs = syn_start;
            he = syn_end;
          end
          stalling = 1'b1;
          syn_rdy  = 1'b0;
          st--;
        end else begin
          stalling = 1'b0;
          syn_rdy  = 1'b1;
          if (em_n < 8) begin
            em_start[em_n] = syn_start;
            em_end[em_n]   = syn_end;
          end
          em_n++;
        end
      end else begin
        syn_rdy = 1'b1;
      end
      if (!got_done) tick();
    end
    syn_rdy = 1'b1;
    vec_cnt++;
    if (!got_done) begin
      err_cnt++;
      $display("FAIL scan_timeout step_done=%b required 1", got_done);
    end
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!axon_rdy && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    repeat (3) tick();
    vec_cnt++;
    if ({syn_vld, step_done, clear_done, axon_rdy} !== 4'b0 || syn_start !== 12'h0 ||
        syn_end !== 12'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs vld/sd/cd/rdy=%b%b%b%b start=%h end=%h required all 0",
               syn_vld, step_done, clear_done, axon_rdy, syn_start, syn_end);
    end
    reset = 1'b0;
    wait_rdy(n);
    vec_cnt++;
    if (n != 256) begin
      err_cnt++;
      $display("FAIL wipe_length cycles=%0d required 256", n);
    end
  endtask

  task automatic test_immediate;
    cfg_write(5, cfgw(0, 'h100, 4));
    fire(5);
    tick();
    vec_cnt++;
    if (syn_vld !== 1'b0) begin
      err_cnt++;
      $display("FAIL imm_early syn_vld=%b required 0 at T+2", syn_vld);
    end
    tick();
    vec_cnt++;
    if (syn_vld !== 1'b1 || syn_start !== 12'h100 || syn_end !== 12'h103) begin
      err_cnt++;
      $display("FAIL imm_out vld=%b start=%h end=%h required 1 100 103", syn_vld, syn_start,
               syn_end);
    end
    tick();
    vec_cnt++;
    if (syn_vld !== 1'b0) begin
      err_cnt++;
      $display("FAIL imm_drain syn_vld=%b required 0", syn_vld);
    end
    run_scan(0);
    vec_cnt++;
    if (em_n != 0) begin
      err_cnt++;
      $display("FAIL imm_scan outputs=%0d required 0", em_n);
    end
    tick();
    vec_cnt++;
    if (step_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL step_done_pulse step_done=%b required 0 after one cycle", step_done);
    end
  endtask

  task automatic test_delay;
    int seen [3];
    cfg_write(7, cfgw(3, 'h020, 2));
    fire(7);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      run_scan(0);
      seen[k] = em_n;
    end
    vec_cnt++;
    if (seen[0] != 0 || seen[1] != 0 || seen[2] != 1) begin
      err_cnt++;
      $display("FAIL delay3_scans counts=%0d,%0d,%0d required 0,0,1", seen[0], seen[1], seen[2]);
    end
    vec_cnt++;
    if (em_start[0] !== 12'h020 || em_end[0] !== 12'h021) begin
      err_cnt++;
      $display("FAIL delay3_range start=%h end=%h required 020 021", em_start[0], em_end[0]);
    end
  endtask

  task automatic test_merge;
    int seen [3];
    cfg_write(9, cfgw(2, 'h300, 1));
    fire(9);
    repeat (2) tick();
    fire(9);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      run_scan(0);
      seen[k] = em_n;
    end
    vec_cnt++;
    if (seen[0] != 0 || seen[1] != 1 || seen[2] != 0) begin
      err_cnt++;
      $display("FAIL merge_scans counts=%0d,%0d,%0d required 0,1,0", seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_back_to_back;
    int addrs [3] = '{1, 1, 2};
    int n;
    cfg_write(1, cfgw(1, 'h010, 3));
    cfg_write(2, cfgw(1, 'h040, 2));
    wait_rdy(n);
    foreach (addrs[i]) begin
      axon_addr = addrs[i][7:0];
      axon_vld  = 1'b1;
      vec_cnt++;
      if (axon_rdy !== 1'b1) begin
        err_cnt++;
        $display("FAIL b2b_rdy fire=%0d axon_rdy=%b required 1", i, axon_rdy);
      end
      tick();
    end
    axon_vld = 1'b0;
    repeat (3) tick();
    run_scan(5);
    vec_cnt++;
    if (em_n != 2 || em_start[0] !== 12'h010 || em_end[0] !== 12'h012 ||
        em_start[1] !== 12'h040 || em_end[1] !== 12'h041) begin
      err_cnt++;
      $display("FAIL b2b_scan n=%0d r0=%h..%h r1=%h..%h required 2 010..012 040..041", em_n,
               em_start[0], em_end[0], em_start[1], em_end[1]);
    end
    vec_cnt++;
    if (!stall_ok) begin
      err_cnt++;
      $display("FAIL stall_hold stable=%b required 1", stall_ok);
    end
    run_scan(0);
    vec_cnt++;
    if (em_n != 0) begin
      err_cnt++;
      $display("FAIL b2b_rescan outputs=%0d required 0", em_n);
    end
  endtask

  task automatic test_wrap_zero;
    int bad = 0;
    cfg_write(20, cfgw(0, 'hFFE, 4));
    fire(20);
    repeat (2) tick();
    vec_cnt++;
    if (syn_vld !== 1'b1 || syn_start !== 12'hFFE || syn_end !== 12'h001) begin
      err_cnt++;
      $display("FAIL wrap_out vld=%b start=%h end=%h required 1 ffe 001", syn_vld, syn_start,
               syn_end);
    end
    tick();
    cfg_write(21, cfgw(0, 'h123, 0));
    fire(21);
    for (int i = 0; i < 5; i++) begin
      if (syn_vld) bad++;
      tick();
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL zero_count vld_cycles=%0d required 0", bad);
    end
  endtask

  task automatic test_pend;
    int dones = 0;
    next_step = 1'b1;
    tick();
    next_step = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      next_step = (i == 10 || i == 20 || i == 30);
      if (step_done) dones++;
      tick();
    end
    next_step = 1'b0;
    vec_cnt++;
    if (dones != 2) begin
      err_cnt++;
      $display("FAIL pend_step scans=%0d required 2", dones);
    end
  endtask

  task automatic test_clear;
    int n, em = 0, rdy_bad = 0, bad = 0;
    logic saw_done = 1'b0, saw_cd = 1'b0, cd_after = 1'b0;
    logic [11:0] st = '0;
    cfg_write(30, cfgw(1, 'h500, 1));
    fire(30);
    repeat (3) tick();
    next_step = 1'b1;
    tick();
    next_step = 1'b0;
    repeat (10) tick();
    clear = 1'b1;
    for (int i = 0; i < 2000 && !saw_cd; i++) begin
      if (syn_vld) begin
        em++;
        st = syn_start;
      end
      if (step_done) saw_done = 1'b1;
      if (clear_done) begin
        saw_cd   = 1'b1;
        cd_after = saw_done;
      end
      if (axon_rdy) rdy_bad++;
      tick();
    end
    clear = 1'b0;
    vec_cnt++;
    if (!saw_cd || !cd_after || em != 1 || st !== 12'h500 || rdy_bad != 0) begin
      err_cnt++;
      $display("FAIL clear_mid_scan cd=%b after_step=%b outs=%0d start=%h rdy=%0d required 1 1 1 500 0",
               saw_cd, cd_after, em, st, rdy_bad);
    end
    // Neuron 5 had count 4 before the clear; a zeroed entry must produce nothing.
    fire(5);
    for (int i = 0; i < 5; i++) begin
      if (syn_vld) bad++;
      tick();
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL clear_cfg vld_cycles=%0d required 0", bad);
    end
    wait_rdy(n);
    clear = 1'b1;
    n = 0;
    while (!clear_done && n < 400) begin
      tick();
      n++;
    end
    clear = 1'b0;
    // One edge to enter the sweep, then 256 sweep cycles.
    vec_cnt++;
    if (n != 257) begin
      err_cnt++;
      $display("FAIL clear_length edges=%0d required 257", n);
    end
  endtask

  task automatic test_reset_mid;
    int n, tot = 0, s1, s2;
    cfg_write(40, cfgw(2, 'h600, 1));
    fire(40);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    wait_rdy(n);
    for (int k = 0; k < 3; k++) begin
      run_scan(0);
      tot += em_n;
    end
    vec_cnt++;
    if (tot != 0) begin
      err_cnt++;
      $display("FAIL reset_stale outputs=%0d required 0", tot);
    end
    fire(40);
    repeat (3) tick();
    run_scan(0);
    s1 = em_n;
    run_scan(0);
    s2 = em_n;
    vec_cnt++;
    if (s1 != 0 || s2 != 1 || em_start[0] !== 12'h600) begin
      err_cnt++;
      $display("FAIL reset_cfg_kept counts=%0d,%0d start=%h required 0,1 600", s1, s2,
               em_start[0]);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_delay();
    test_merge();
    test_back_to_back();
    test_wrap_zero();
    test_pend();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
